// File: rtl/bk_pkg.sv
// ----------------------------------------------------------------------------
// bk_pkg -- shared definitions for the Brent-Kung adder stages.
//
// Contents:
//   BK_WIDTH    default operand width of the adder datapath
//   bk_state_e  occupancy state of the two-entry output skid buffer
// ----------------------------------------------------------------------------
package bk_pkg;

   localparam int BK_WIDTH = 16;

   // EMPTY: no beat held; ONE: main register holds a beat;
   // TWO: main and skid registers both hold beats (upstream stalled).
   typedef enum logic [1:0] {
      EMPTY = 2'd0,
      ONE   = 2'd1,
      TWO   = 2'd2
   } bk_state_e;

endpackage : bk_pkg

// File: rtl/bk_sum_xor.sv
// ----------------------------------------------------------------------------
// bk_sum_xor -- final sum/flag logic of the Brent-Kung adder.
//
// Ports:
//   p    [WIDTH:0]   bitwise propagate; bit 0 is the cin slot (ignored),
//                    bit i+1 belongs to operand bit i
//   gi   [WIDTH:0]   group generate; bit j is the carry out of slots 0..j,
//                    bit 0 is cin
//   sum  [WIDTH-1:0] sum bits
//   cout             carry out of the MSB
//   ovf              two's-complement overflow
//   zero             sum is all zeros
// ----------------------------------------------------------------------------
module bk_sum_xor #(
   parameter int WIDTH = 16
) (
   input  logic [WIDTH:0]   p,
   input  logic [WIDTH:0]   gi,
   output logic [WIDTH-1:0] sum,
   output logic             cout,
   output logic             ovf,
   output logic             zero
);

   // The cin slot has no operand bit, so its propagate never reaches a sum.
   logic unused_p0;
   assign unused_p0 = p[0];

   // gi[i] is the carry into operand bit i.
   assign sum  = p[WIDTH:1] ^ gi[WIDTH-1:0];
   assign cout = gi[WIDTH];
   // Carry out of the MSB differs from carry into the MSB.
   assign ovf  = gi[WIDTH] ^ gi[WIDTH-1];
   assign zero = ~|sum;

endmodule : bk_sum_xor

// File: rtl/bk_sum_stage.sv
// ----------------------------------------------------------------------------
// bk_sum_stage -- registered sum stage of the Brent-Kung adder with a
// two-entry skid buffer on its output.
//
// Ports:
//   clk, rst_n          clock; asynchronous active-low reset
//   in_valid/in_ready   upstream handshake
//   in_p   [WIDTH:0]    bitwise propagate (bit 0 = cin slot, ignored)
//   in_gi  [WIDTH:0]    group generate (bit 0 = cin)
//   out_valid/out_ready downstream handshake
//   out_sum [WIDTH-1:0] registered sum
//   out_cout, out_ovf, out_zero  registered flags
//
// Handshake: a beat moves across an interface only on a rising clk edge at
// which both valid and ready of that interface are high. A producer holding
// valid high keeps its payload stable until the transfer; ready may be high
// without valid. in_ready comes straight from a flop, so there is no
// combinational path from out_ready to in_ready; the skid register absorbs
// the one beat that can arrive in the cycle after downstream stalls.
//
// The buffer occupancy is observable as state_q (bk_state_e).
// ----------------------------------------------------------------------------
module bk_sum_stage
   import bk_pkg::*;
#(
   parameter int WIDTH   = BK_WIDTH,
   parameter int VALENCY = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH:0]   in_p,
   input  logic [WIDTH:0]   in_gi,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_sum,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero
);

   // VALENCY only keeps the parameter list aligned with the other stages.
   localparam int unused_valency = VALENCY;

   // Payload layout: {sum, cout, ovf, zero}
   localparam int PW = WIDTH + 3;

   bk_state_e        state_q;
   bk_state_e        state_n;
   logic             in_ready_q;
   logic [PW-1:0]    main_q;
   logic [PW-1:0]    skid_q;
   logic [PW-1:0]    main_n;
   logic             load_main;
   logic             load_skid;
   logic             accept;
   logic             xfer;

   logic [WIDTH-1:0] res_sum;
   logic             res_cout;
   logic             res_ovf;
   logic             res_zero;
   logic [PW-1:0]    res;

   bk_sum_xor #(
      .WIDTH (WIDTH)
   ) u_sum_xor (
      .p    (in_p),
      .gi   (in_gi),
      .sum  (res_sum),
      .cout (res_cout),
      .ovf  (res_ovf),
      .zero (res_zero)
   );

   assign res = {res_sum, res_cout, res_ovf, res_zero};

   assign out_valid = (state_q != EMPTY);
   assign in_ready  = in_ready_q;
   assign accept    = in_valid & in_ready_q;
   assign xfer      = out_valid & out_ready;

   // ---------------------------------------------------------------- FSM
   always_comb begin
      state_n   = state_q;
      load_main = 1'b0;
      load_skid = 1'b0;
      main_n    = res;
      unique case (state_q)
         EMPTY: begin
            if (accept) begin
               state_n   = ONE;
               load_main = 1'b1;
            end
         end
         ONE: begin
            if (accept && xfer) begin
               load_main = 1'b1;
            end else if (accept) begin
               // Downstream stalled: park the new beat behind the held one.
               state_n   = TWO;
               load_skid = 1'b1;
            end else if (xfer) begin
               state_n = EMPTY;
            end
         end
         TWO: begin
            // in_ready is low here, so no accept can coincide.
            if (xfer) begin
               state_n   = ONE;
               load_main = 1'b1;
               main_n    = skid_q;
            end
         end
         default: begin
            state_n = EMPTY;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= EMPTY;
         in_ready_q <= 1'b0;
         main_q     <= '0;
         skid_q     <= '0;
      end else begin
         state_q    <= state_n;
         // Registered ready: open whenever the skid register will be free.
         in_ready_q <= (state_n != TWO);
         if (load_main) begin
            main_q <= main_n;
         end
         if (load_skid) begin
            skid_q <= res;
         end
      end
   end

   assign out_sum  = main_q[PW-1:3];
   assign out_cout = main_q[2];
   assign out_ovf  = main_q[1];
   assign out_zero = main_q[0];

endmodule : bk_sum_stage

// File: tb/tb_bk_sum_stage.sv
// ----------------------------------------------------------------------------
// tb_bk_sum_stage -- self-checking bench for bk_sum_stage (WIDTH = 16).
// Inputs are driven on the falling edge; outputs are sampled on the falling
// edge, half a cycle away from the active rising edge.
// ----------------------------------------------------------------------------
module tb_bk_sum_stage;

   localparam int W = 16;

   // ------------------------------------------------ clock / reset block
   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         in_ready;
   logic [W:0]   in_p;
   logic [W:0]   in_gi;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_sum;
   logic         out_cout;
   logic         out_ovf;
   logic         out_zero;

   always #5 clk = ~clk;

   bk_sum_stage #(
      .WIDTH   (W),
      .VALENCY (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_p      (in_p),
      .in_gi     (in_gi),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_sum   (out_sum),
      .out_cout  (out_cout),
      .out_ovf   (out_ovf),
      .out_zero  (out_zero)
   );

   int n_cmp  = 0;
   int n_fail = 0;

   // Scoreboard: {sum, cout, ovf, zero} in acceptance order.
   logic [W+2:0] exp_q[$];

   // ------------------------------------------------ reference helpers
   // Upstream prefix network: propagate/generate vectors for a + b + cin.
   function automatic logic [W:0] mk_p(input logic [W-1:0] a, input logic [W-1:0] b);
      return {a ^ b, 1'b0};
   endfunction

   function automatic logic [W:0] mk_gi(input logic [W-1:0] a, input logic [W-1:0] b,
                                        input logic cin);
      logic [W:0] gi;
      gi[0] = cin;
      for (int i = 0; i < W; i++) begin
         gi[i+1] = (a[i] & b[i]) | ((a[i] ^ b[i]) & gi[i]);
      end
      return gi;
   endfunction

   // Arithmetic expectation from a plain integer add.
   function automatic logic [W+2:0] exp_of(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic cin);
      logic [W:0] s;
      logic       v;
      s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, cin};
      v = (a[W-1] == b[W-1]) && (s[W-1] != a[W-1]);
      return {s[W-1:0], s[W], v, (s[W-1:0] == '0)};
   endfunction

   // ------------------------------------------------ driver tasks
   task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic cin);
      in_p  = mk_p(a, b);
      in_gi = mk_gi(a, b, cin);
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_out(input string tag, input logic [W-1:0] s, input logic c,
                            input logic v, input logic z);
      check({tag, "_valid"}, 32'(out_valid), 32'd1);
      check({tag, "_sum"},   32'(out_sum),   32'(s));
      check({tag, "_cout"},  32'(out_cout),  32'(c));
      check({tag, "_ovf"},   32'(out_ovf),   32'(v));
      check({tag, "_zero"},  32'(out_zero),  32'(z));
   endtask

   // ------------------------------------------------ directed sequence
   initial begin
      logic [W-1:0] ra;
      logic [W-1:0] rb;
      logic         rc;
      int           sent;
      int           got;
      int           cyc;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      drive(16'h0000, 16'h0000, 1'b0);

      // Reset state, before any clock edge.
      #1;
      check("rst_in_ready",  32'(in_ready),  32'd0);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_out_sum",   32'(out_sum),   32'd0);
      check("rst_out_flags", 32'({out_cout, out_ovf, out_zero}), 32'd0);

      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      check("rel_in_ready_before_edge", 32'(in_ready), 32'd0);
      @(negedge clk);
      check("rel_in_ready_after_edge", 32'(in_ready), 32'd1);

      // 0x00FF + 0x0001
      out_ready = 1'b1;
      in_valid  = 1'b1;
      drive(16'h00FF, 16'h0001, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check_out("v1", 16'h0100, 1'b0, 1'b0, 1'b0);

      // 0xFFFF + 0x0001 : wraps to zero with carry out
      @(negedge clk);
      in_valid = 1'b1;
      drive(16'hFFFF, 16'h0001, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check_out("v2", 16'h0000, 1'b1, 1'b0, 1'b1);

      // 0x7FFF + 0x0000 + cin : signed overflow
      @(negedge clk);
      in_valid = 1'b1;
      drive(16'h7FFF, 16'h0000, 1'b1);
      @(negedge clk);
      in_valid = 1'b0;
      check_out("v3", 16'h8000, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      check("v3_drained", 32'(out_valid), 32'd0);

      // Back-pressure: three beats offered with out_ready low.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(16'h0001, 16'h0002, 1'b0);          // beat 1 = 0x0003
      @(negedge clk);
      drive(16'h0010, 16'h0020, 1'b0);          // beat 2 = 0x0030
      check("bp_ready_b2", 32'(in_ready), 32'd1);
      @(negedge clk);
      drive(16'h0100, 16'h0200, 1'b0);          // beat 3 = 0x0300
      check("bp_ready_low", 32'(in_ready), 32'd0);
      check_out("bp_hold1", 16'h0003, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("bp_ready_still_low", 32'(in_ready), 32'd0);
      check_out("bp_hold2", 16'h0003, 1'b0, 1'b0, 1'b0);
      out_ready = 1'b1;
      @(negedge clk);
      check_out("bp_beat2", 16'h0030, 1'b0, 1'b0, 1'b0);
      check("bp_ready_reopen", 32'(in_ready), 32'd1);
      @(negedge clk);
      in_valid = 1'b0;
      check_out("bp_beat3", 16'h0300, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      check("bp_drained", 32'(out_valid), 32'd0);

      // Reset while two beats are held.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive(16'h0005, 16'h0006, 1'b0);
      @(negedge clk);
      drive(16'h0007, 16'h0008, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check("two_ready", 32'(in_ready), 32'd0);
      check("two_valid", 32'(out_valid), 32'd1);
      #2;
      rst_n = 1'b0;
      #1;
      check("mid_rst_valid", 32'(out_valid), 32'd0);
      check("mid_rst_ready", 32'(in_ready),  32'd0);
      check("mid_rst_sum",   32'(out_sum),   32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      check("post_rst_ready", 32'(in_ready), 32'd1);
      out_ready = 1'b1;
      for (int i = 0; i < 3; i++) begin
         check("post_rst_no_stale", 32'(out_valid), 32'd0);
         @(negedge clk);
      end
      in_valid = 1'b1;
      drive(16'h1234, 16'h0001, 1'b0);
      @(negedge clk);
      in_valid = 1'b0;
      check_out("post_rst_beat", 16'h1235, 1'b0, 1'b0, 1'b0);
      @(negedge clk);

      // Random valid/ready toggling, 1000 beats through the scoreboard.
      sent = 0;
      got  = 0;
      cyc  = 0;
      while ((sent < 1000 || exp_q.size() != 0) && cyc < 20000) begin
         out_ready = ($urandom_range(0, 3) != 0);
         in_valid  = (sent < 1000) && ($urandom_range(0, 3) != 0);
         ra = 16'($urandom);
         rb = 16'($urandom);
         rc = 1'($urandom_range(0, 1));
         drive(ra, rb, rc);
         if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
               check("rand_spurious_beat", 32'd1, 32'd0);
            end else begin
               check("rand_beat", 32'({out_sum, out_cout, out_ovf, out_zero}),
                     32'(exp_q.pop_front()));
               got++;
            end
         end
         if (in_valid && in_ready) begin
            exp_q.push_back(exp_of(ra, rb, rc));
            sent++;
         end
         @(negedge clk);
         cyc++;
      end
      in_valid = 1'b0;
      check("rand_delivered", 32'(got), 32'd1000);
      check("rand_queue_empty", 32'(exp_q.size()), 32'd0);
      check("rand_final_idle", 32'(out_valid), 32'd0);

      // ---------------------------------------------- final report
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule : tb_bk_sum_stage
